// File: rtl/ft600_tx.sv
// FT600 245 synchronous-FIFO transmit path: 2-deep word buffer feeding bursts
// onto the FT600 bus, with bus turnaround and yield to the receive path.
module ft600_tx #(
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 0
) (
  input  logic        i_ft_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic [1:0]  i_be,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_rx_req,
  input  logic        i_ft_txe_n,
  output logic [15:0] o_ft_data,
  output logic [1:0]  o_ft_be,
  output logic        o_ft_data_oe,
  output logic        o_ft_wr_n,
  output logic        o_busy,
  output logic [31:0] o_words
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  localparam logic [3:0]  TURN_LOAD = 4'(TURNAROUND - 1);
  localparam logic [15:0] BURST_MAX = 16'(MAX_BURST);

  state_t      state;
  logic [17:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [3:0]  turn_cnt;
  logic [15:0] burst_cnt;
  logic        push;
  logic        accept;
  logic        last_word;
  logic        burst_full;

  assign o_ready    = (count < 2'd2) && !i_rst;
  assign push       = i_valid && o_ready;
  assign accept     = !o_ft_wr_n && !i_ft_txe_n;
  assign last_word  = (count == 2'd1) && !push;
  assign burst_full = (BURST_MAX != '0) && ((burst_cnt + 16'd1) == BURST_MAX);

  // Buffer storage is cleared on reset so the bus data/BE read as zero then.
  assign {o_ft_be, o_ft_data} = fifo_mem[rd_ptr];
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_ft_clk or posedge i_rst) begin
    if (i_rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {i_be, i_data};
        wr_ptr           <= !wr_ptr;
      end
      if (accept) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, accept})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_ft_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_ft_data_oe <= 1'b0;
      o_ft_wr_n    <= 1'b1;
      o_words      <= '0;
      turn_cnt     <= '0;
      burst_cnt    <= '0;
    end else begin
      if (accept) begin
        o_words   <= o_words + 32'd1;
        burst_cnt <= burst_cnt + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if ((count != 2'd0) && !i_ft_txe_n && !i_rx_req) begin
            state        <= ST_TURN;
            o_ft_data_oe <= 1'b1;
            turn_cnt     <= TURN_LOAD;
            burst_cnt    <= '0;
          end
        end
        ST_TURN: begin
          if (turn_cnt == '0) begin
            state     <= ST_WRITE;
            o_ft_wr_n <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        ST_WRITE: begin
          // A pending rx request ends the burst whether or not this edge accepts.
          if ((accept && (last_word || burst_full)) || i_rx_req) begin
            state     <= ST_RELEASE;
            o_ft_wr_n <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state        <= ST_IDLE;
          o_ft_data_oe <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          o_ft_data_oe <= 1'b0;
          o_ft_wr_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_tx.sv
// Bench for ft600_tx: two instances (default, and TURNAROUND=2/MAX_BURST=2)
// checked every cycle against a queue-and-rules model, plus literal scenarios.
`timescale 1ns/1ps
module tb_ft600_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        txe_n = 1'b0;
  logic        rx_req = 1'b0;
  logic [15:0] d [2];
  logic [1:0]  be [2];
  logic        v [2];
  logic        rdy [2];
  logic        oe [2];
  logic        wrn [2];
  logic        busy [2];
  logic [15:0] fd [2];
  logic [1:0]  fbe [2];
  logic [31:0] words [2];

  always #5 clk = ~clk;

  ft600_tx #(.TURNAROUND(1), .MAX_BURST(0)) u_dut0 (
    .i_ft_clk(clk), .i_rst(rst), .i_data(d[0]), .i_be(be[0]), .i_valid(v[0]),
    .o_ready(rdy[0]), .i_rx_req(rx_req), .i_ft_txe_n(txe_n), .o_ft_data(fd[0]),
    .o_ft_be(fbe[0]), .o_ft_data_oe(oe[0]), .o_ft_wr_n(wrn[0]), .o_busy(busy[0]),
    .o_words(words[0])
  );

  ft600_tx #(.TURNAROUND(2), .MAX_BURST(2)) u_dut1 (
    .i_ft_clk(clk), .i_rst(rst), .i_data(d[1]), .i_be(be[1]), .i_valid(v[1]),
    .o_ready(rdy[1]), .i_rx_req(rx_req), .i_ft_txe_n(txe_n), .o_ft_data(fd[1]),
    .o_ft_be(fbe[1]), .o_ft_data_oe(oe[1]), .o_ft_wr_n(wrn[1]), .o_busy(busy[1]),
    .o_words(words[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state per instance
  logic [17:0] mbuf [2][4];
  int          mhd [2];
  int          mcnt [2];
  logic [31:0] mwords [2];
  int          run [2];
  int          bcnt [2];
  logic        prev_wrn [2];
  logic        exp_ok [2];
  logic        exp_oe [2];
  logic        exp_wrn [2];
  // scenario statistics
  int          acc_cnt [2];
  int          low_cyc [2];
  int          low_run [2];
  int          max_low_run [2];
  int          oe_cyc [2];
  int          bursts [2];
  logic [15:0] last_data [2];

  function automatic int tp_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int mb_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic tfail(input string name, input int k);
    checks++;
    failures++;
    $display("FAIL %s[%0d] cycle %0d: wait bound expired", name, k, cyc);
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        logic pushing;
        logic acc;
        logic ends;
        if (rst) begin
          chk("rst_wr_n", k, 32'(wrn[k]), 32'd1);
          chk("rst_oe", k, 32'(oe[k]), 32'd0);
          chk("rst_data", k, 32'({fbe[k], fd[k]}), 32'd0);
          chk("rst_busy", k, 32'(busy[k]), 32'd0);
          chk("rst_words", k, words[k], 32'd0);
          chk("rst_ready", k, 32'(rdy[k]), 32'd0);
          mhd[k] = 0; mcnt[k] = 0; mwords[k] = '0;
          run[k] = 0; bcnt[k] = 0; prev_wrn[k] = 1'b1;
          exp_ok[k] = 1'b1; exp_oe[k] = 1'b0; exp_wrn[k] = 1'b1;
        end else begin
          chk("ready", k, 32'(rdy[k]), 32'(mcnt[k] < 2));
          chk("words", k, words[k], mwords[k]);
          chk("busy", k, 32'(busy[k]), 32'(oe[k]));
          if (exp_ok[k]) begin
            chk("oe", k, 32'(oe[k]), 32'(exp_oe[k]));
            chk("wr_n", k, 32'(wrn[k]), 32'(exp_wrn[k]));
          end
          if (!wrn[k]) begin
            chk("oe_while_wr", k, 32'(oe[k]), 32'd1);
            if (mcnt[k] > 0) chk("head", k, 32'({fbe[k], fd[k]}), 32'(mbuf[k][mhd[k]]));
            else tfail("write_with_empty_buffer", k);
            low_cyc[k]++;
            low_run[k]++;
            if (low_run[k] > max_low_run[k]) max_low_run[k] = low_run[k];
          end else begin
            low_run[k] = 0;
          end
          if (oe[k]) oe_cyc[k]++;

          pushing = v[k] && (mcnt[k] < 2);
          acc = !wrn[k] && !txe_n;
          exp_ok[k] = 1'b1;
          if (!oe[k]) begin
            run[k] = 0;
            bcnt[k] = 0;
            exp_oe[k] = (mcnt[k] > 0) && !txe_n && !rx_req;
            exp_wrn[k] = 1'b1;
          end else if (!wrn[k]) begin
            exp_oe[k] = 1'b1;
            if (acc) begin
              bcnt[k]++;
              ends = ((mcnt[k] == 1) && !pushing) || ((mb_of(k) != 0) && (bcnt[k] == mb_of(k))) || rx_req;
              exp_wrn[k] = ends;
            end else begin
              exp_wrn[k] = rx_req;
            end
          end else if (!prev_wrn[k]) begin
            bursts[k]++;
            exp_oe[k] = 1'b0;
            exp_wrn[k] = 1'b1;
          end else begin
            run[k]++;
            exp_oe[k] = 1'b1;
            exp_wrn[k] = (run[k] != tp_of(k));
          end

          if (acc && mcnt[k] > 0) begin
            acc_cnt[k]++;
            last_data[k] = fd[k];
            mhd[k] = (mhd[k] + 1) % 4;
            mcnt[k]--;
            mwords[k] = mwords[k] + 32'd1;
          end
          if (pushing) begin
            mbuf[k][(mhd[k] + mcnt[k]) % 4] = {be[k], d[k]};
            mcnt[k]++;
          end
          prev_wrn[k] = wrn[k];
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr(input int k);
    acc_cnt[k] = 0; low_cyc[k] = 0; low_run[k] = 0; max_low_run[k] = 0;
    oe_cyc[k] = 0; bursts[k] = 0; last_data[k] = '0;
  endtask

  task automatic push_word(input int k, input logic [15:0] data, input logic [1:0] bv);
    int guard = 0;
    d[k] = data; be[k] = bv; v[k] = 1'b1;
    while (!rdy[k] && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) tfail("push_timeout", k);
    tick(1);
  endtask

  task automatic wait_drain(input int k);
    int guard = 0;
    while ((mcnt[k] != 0 || oe[k]) && guard < 500) begin
      tick(1);
      guard++;
    end
    if (guard >= 500) tfail("drain_timeout", k);
  endtask

  task automatic wait_acc(input int k, input int n);
    int guard = 0;
    while (acc_cnt[k] < n && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) tfail("accept_timeout", k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      d[k] = '0; be[k] = '0; v[k] = 1'b0;
      exp_ok[k] = 1'b0; exp_oe[k] = 1'b0; exp_wrn[k] = 1'b1; prev_wrn[k] = 1'b1;
      mhd[k] = 0; mcnt[k] = 0; mwords[k] = '0; run[k] = 0; bcnt[k] = 0;
      clr(k);
    end
    fork
      checker_loop();
    join_none

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // single word
    clr(0);
    push_word(0, 16'hA5A5, 2'b11);
    v[0] = 1'b0;
    wait_drain(0);
    tick(1);
    chk("single_low_cycles", 0, 32'(low_cyc[0]), 32'd1);
    chk("single_oe_cycles", 0, 32'(oe_cyc[0]), 32'd3);
    chk("single_words", 0, words[0], 32'd1);
    chk("single_data", 0, 32'(last_data[0]), 32'hA5A5);

    // streaming 8 words in one burst
    clr(0);
    for (int i = 0; i < 8; i++) push_word(0, 16'(i), 2'b11);
    v[0] = 1'b0;
    wait_drain(0);
    tick(1);
    chk("stream_run", 0, 32'(max_low_run[0]), 32'd8);
    chk("stream_bursts", 0, 32'(bursts[0]), 32'd1);
    chk("stream_words", 0, words[0], 32'd9);
    chk("stream_last", 0, 32'(last_data[0]), 32'h0007);

    // TX FIFO stall after the 2nd accept
    clr(0);
    fork
      begin
        for (int i = 0; i < 4; i++) push_word(0, 16'(16'h0100 + i), 2'b01);
        v[0] = 1'b0;
      end
      begin
        wait_acc(0, 2);
        txe_n = 1'b1;
        tick(3);
        txe_n = 1'b0;
      end
    join
    wait_drain(0);
    tick(1);
    chk("stall_run", 0, 32'(max_low_run[0]), 32'd7);
    chk("stall_bursts", 0, 32'(bursts[0]), 32'd1);
    chk("stall_words", 0, words[0], 32'd13);
    chk("stall_last", 0, 32'(last_data[0]), 32'h0103);

    // MAX_BURST=2 instance: 5 words split 2,2,1
    clr(1);
    for (int i = 0; i < 5; i++) push_word(1, 16'(16'h0200 + i), 2'b10);
    v[1] = 1'b0;
    wait_drain(1);
    tick(1);
    chk("maxb_bursts", 1, 32'(bursts[1]), 32'd3);
    chk("maxb_run", 1, 32'(max_low_run[1]), 32'd2);
    chk("maxb_words", 1, words[1], 32'd5);
    chk("maxb_last", 1, 32'(last_data[1]), 32'h0204);

    // bus yield after the 2nd accept
    clr(0);
    fork
      begin
        for (int i = 0; i < 6; i++) push_word(0, 16'(16'h0300 + i), 2'b11);
        v[0] = 1'b0;
      end
      begin
        wait_acc(0, 2);
        rx_req = 1'b1;
        tick(6);
        chk("yield_accepts", 0, 32'(acc_cnt[0]), 32'd3);
        chk("yield_idle", 0, 32'(busy[0]), 32'd0);
        rx_req = 1'b0;
      end
    join
    wait_drain(0);
    tick(1);
    chk("yield_total", 0, 32'(acc_cnt[0]), 32'd6);
    chk("yield_words", 0, words[0], 32'd19);
    chk("yield_last", 0, 32'(last_data[0]), 32'h0305);

    // asynchronous reset mid-burst
    clr(0);
    for (int i = 0; i < 6; i++) begin
      push_word(0, 16'(16'h0400 + i), 2'b11);
      if (acc_cnt[0] >= 2) break;
    end
    chk("midburst_wr_n_low", 0, 32'(wrn[0]), 32'd0);
    rst = 1'b1;
    v[0] = 1'b0;
    #1;
    chk("async_wr_n", 0, 32'(wrn[0]), 32'd1);
    chk("async_oe", 0, 32'(oe[0]), 32'd0);
    chk("async_words", 0, words[0], 32'd0);
    chk("async_data", 0, 32'(fd[0]), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    clr(0);
    push_word(0, 16'h1234, 2'b11);
    v[0] = 1'b0;
    wait_drain(0);
    tick(1);
    chk("post_rst_words", 0, words[0], 32'd1);
    chk("post_rst_data", 0, 32'(last_data[0]), 32'h1234);
    chk("post_rst_low", 0, 32'(low_cyc[0]), 32'd1);

    // randomized traffic with stalls, yields and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        v[k] = ($urandom_range(0, 99) < 60);
        d[k] = 16'($urandom);
        be[k] = 2'($urandom);
      end
      txe_n = ($urandom_range(0, 99) < 20);
      rx_req = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    txe_n = 1'b0; rx_req = 1'b0; rst = 1'b0;
    tick(1);
    wait_drain(0);
    wait_drain(1);
    tick(2);
    chk("final_words0", 0, words[0], mwords[0]);
    chk("final_words1", 1, words[1], mwords[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
